ram_stream_reader: RTL and testbench

- Initiator for the synchronous RAM read-request/read-response handshake; the requester end of the collision-checked 1R1W RAM wrapper.
- Accepts a command (start address, length) and issues consecutive read requests with address wrap-around.
- Collects the responses and emits them as a valid/ready stream with a last flag, through a registered 2-entry skid buffer.
- Sits between table-walk or packet-readout logic and a RAM instance.

---
 rtl/ram_stream_reader_pkg.sv | 18 +
 rtl/ram_rd_skid_buf.sv | 49 ++++
 rtl/ram_stream_reader.sv | 139 +++++++++++++
 tb/tb_ram_stream_reader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_stream_reader_pkg.sv
// Shared types for the RAM stream reader: FSM states and the default skid buffer entry.
package ram_stream_reader_pkg;

  localparam int unsigned DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Default entry shape; instantiating modules pass their own width-matched struct.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
  } skid_entry_t;

endpackage

// File: rtl/ram_rd_skid_buf.sv
// Two-entry valid/ready buffer with registered outputs; in-order, 1-cycle latency,
// full throughput when the consumer is always ready.
module ram_rd_skid_buf
  import ram_stream_reader_pkg::*;
#(
  parameter type entry_t = skid_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_val,
  input  entry_t in_data,
  output logic   in_rdy,
  output logic   out_val,
  output entry_t out_data,
  input  logic   out_rdy
);

  logic   skid_val;
  entry_t skid;
  logic   push;
  logic   head_load;

  // The skid slot only fills when the head is stalled, so it being empty means "not full".
  assign in_rdy    = !skid_val;
  assign push      = in_val && !skid_val;
  assign head_load = !out_val || out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_val  <= 1'b0;
      out_data <= '0;
      skid_val <= 1'b0;
      skid     <= '0;
    end else if (head_load) begin
      if (skid_val) begin
        out_val  <= 1'b1;
        out_data <= skid;
        skid_val <= 1'b0;
      end else begin
        out_val <= push;
        if (push) out_data <= in_data;
      end
    end else if (push) begin
      skid     <= in_data;
      skid_val <= 1'b1;
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Issues consecutive (wrapping) RAM read requests for a command and streams the
// responses out through a 2-entry skid buffer with a last flag.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned LEN_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_val,
  input  logic [ADDR_W-1:0] cmd_start_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_rdy,
  output logic              rd_req_en,
  output logic [ADDR_W-1:0] rd_req_addr,
  input  logic              rd_req_rdy,
  input  logic              rd_resp_val,
  input  logic [DATA_W-1:0] rd_resp_data,
  output logic              rd_resp_rdy,
  output logic              out_val,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_rdy,
  output logic              busy,
  output logic              done
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } entry_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(DEPTH);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_reg, addr_nxt;
  logic [LEN_W-1:0]  len_reg, len_nxt;
  logic [LEN_W-1:0]  req_cnt, req_nxt;
  logic [LEN_W-1:0]  resp_cnt, resp_nxt;
  logic              done_nxt;
  logic              cmd_fire, req_fire, resp_fire, resp_take;
  logic              buf_in_rdy, buf_out_val;
  entry_t            buf_in, buf_out;

  assign cmd_fire    = cmd_val && cmd_rdy;
  assign req_fire    = rd_req_en && rd_req_rdy;
  // Responses seen while idle are accepted but never enter the buffer.
  assign resp_take   = rd_resp_val && (state != IDLE);
  assign resp_fire   = resp_take && buf_in_rdy;
  assign rd_resp_rdy = buf_in_rdy;
  assign rd_req_addr = addr_reg;
  assign buf_in      = '{data: rd_resp_data, last: (resp_cnt == len_reg - LEN_ONE)};
  assign out_val     = buf_out_val;
  assign out_data    = buf_out.data;
  assign out_last    = buf_out.last;

  // Next-state and counter updates.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_reg;
    len_nxt   = len_reg;
    req_nxt   = req_cnt;
    resp_nxt  = resp_cnt;
    done_nxt  = 1'b0;
    if (resp_fire) resp_nxt = resp_cnt + LEN_ONE;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          addr_nxt = cmd_start_addr;
          len_nxt  = cmd_len;
          req_nxt  = '0;
          resp_nxt = '0;
          if (cmd_len == '0) done_nxt = 1'b1;
          else state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (req_fire) begin
          addr_nxt = (addr_reg == ADDR_LAST) ? '0 : addr_reg + ADDR_W'(1);
          req_nxt  = req_cnt + LEN_ONE;
          if (req_cnt == len_reg - LEN_ONE) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (resp_cnt == len_reg && !buf_out_val) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_reg  <= '0;
      len_reg   <= '0;
      req_cnt   <= '0;
      resp_cnt  <= '0;
      cmd_rdy   <= 1'b1;
      rd_req_en <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr_reg  <= addr_nxt;
      len_reg   <= len_nxt;
      req_cnt   <= req_nxt;
      resp_cnt  <= resp_nxt;
      cmd_rdy   <= (state_nxt == IDLE);
      rd_req_en <= (state_nxt == ISSUE);
      busy      <= (state_nxt != IDLE);
      done      <= done_nxt;
    end
  end

  ram_rd_skid_buf #(
    .entry_t(entry_t)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_val  (resp_take),
    .in_data (buf_in),
    .in_rdy  (buf_in_rdy),
    .out_val (buf_out_val),
    .out_data(buf_out),
    .out_rdy (out_rdy)
  );

  a_cmd_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
    cmd_fire |-> (cmd_len <= LEN_MAX));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench: RAM model plus a queue-based reference of the expected request
// addresses and output beats, compared every cycle.
module tb_ram_stream_reader;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = 9;

  logic              clk, rst_n;
  logic              cmd_val;
  logic [ADDR_W-1:0] cmd_start_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_rdy;
  logic              rd_req_en;
  logic [ADDR_W-1:0] rd_req_addr;
  logic              rd_req_rdy;
  logic              rd_resp_val;
  logic [DATA_W-1:0] rd_resp_data;
  logic              rd_resp_rdy;
  logic              out_val;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_rdy;
  logic              busy, done;

  ram_stream_reader #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_val(cmd_val), .cmd_start_addr(cmd_start_addr), .cmd_len(cmd_len), .cmd_rdy(cmd_rdy),
    .rd_req_en(rd_req_en), .rd_req_addr(rd_req_addr), .rd_req_rdy(rd_req_rdy),
    .rd_resp_val(rd_resp_val), .rd_resp_data(rd_resp_data), .rd_resp_rdy(rd_resp_rdy),
    .out_val(out_val), .out_data(out_data), .out_last(out_last), .out_rdy(out_rdy),
    .busy(busy), .done(done)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ramq [$];

  int checks = 0;
  int errors = 0;

  int                exp_addr [$];
  logic [DATA_W-1:0] exp_data [$];
  logic              exp_last [$];
  int                req_log [$];
  logic [DATA_W-1:0] beat_data [$];
  logic              beat_last [$];
  int                beat_cyc [$];
  int                ref_q [$];
  int                ref_b [$];

  int occ = 0, done_cnt = 0, resp_acc = 0, resp_rdy_low = 0, out_val_cnt = 0;
  int cyc = 0, cmd_cyc0 = 0;
  bit in_cmd = 0, expect_done = 0;
  int rmode = 0, omode = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RAM: accepted requests return mem data one cycle later, held until taken.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramq.delete();
      rd_resp_val  <= 1'b0;
      rd_resp_data <= '0;
    end else begin
      if (rd_resp_val && rd_resp_rdy) void'(ramq.pop_front());
      if (rd_req_en && rd_req_rdy) ramq.push_back(mem[rd_req_addr]);
      rd_resp_val  <= (ramq.size() != 0);
      rd_resp_data <= (ramq.size() != 0) ? ramq[0] : '0;
    end
  end

  // Ready drivers: 0 = always, 1 = directed pattern, 2 = random.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       rd_req_rdy = 1'b1;
      1:       rd_req_rdy = !(req_log.size() >= 1 && req_log.size() <= 3);
      default: rd_req_rdy = ($urandom % 4) != 0;
    endcase
    case (omode)
      0:       out_rdy = 1'b1;
      1:       out_rdy = ((cyc - cmd_cyc0) % 3) == 0;
      default: out_rdy = ($urandom % 2) != 0;
    endcase
  end

  // Per-cycle compare against the reference queues and buffer occupancy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_req_en) begin
        req_log.push_back(int'(rd_req_addr));
        chk("req_expected", 64'(exp_addr.size() != 0), 64'(1));
        if (exp_addr.size() != 0) begin
          chk("req_addr", 64'(rd_req_addr), 64'(exp_addr[0]));
          if (rd_req_rdy) void'(exp_addr.pop_front());
        end
      end
      chk("resp_rdy", 64'(rd_resp_rdy), 64'(occ < 2));
      chk("out_val", 64'(out_val), 64'(occ > 0));
      if (!rd_resp_rdy) resp_rdy_low++;
      if (out_val) begin
        out_val_cnt++;
        chk("beat_expected", 64'(exp_data.size() != 0), 64'(1));
        if (exp_data.size() != 0) begin
          chk("out_data", out_data, exp_data[0]);
          chk("out_last", 64'(out_last), 64'(exp_last[0]));
          if (out_rdy) begin
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
            beat_data.push_back(out_data);
            beat_last.push_back(out_last);
            beat_cyc.push_back(cyc);
          end
        end
      end
      if (done) begin
        chk("done_expected", 64'(expect_done), 64'(1));
        chk("done_drained", 64'(exp_data.size() + exp_addr.size()), 64'(0));
        expect_done = 1'b0;
        in_cmd      = 1'b0;
        done_cnt++;
      end
      chk("busy", 64'(busy), 64'(in_cmd));
      chk("cmd_rdy", 64'(cmd_rdy), 64'(!in_cmd));
      if (rd_resp_val && rd_resp_rdy) begin
        resp_acc++;
        occ++;
      end
      if (out_val && out_rdy) occ--;
    end
  end

  task automatic start_cmd(input int start, input int len);
    int n = 0;
    while (!cmd_rdy && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("cmd_rdy_wait", 64'(cmd_rdy), 64'(1));
    cmd_val        = 1'b1;
    cmd_start_addr = ADDR_W'(start);
    cmd_len        = LEN_W'(len);
    for (int i = 0; i < len; i++) begin
      exp_addr.push_back((start + i) % DEPTH);
      exp_data.push_back(mem[(start + i) % DEPTH]);
      exp_last.push_back(i == len - 1);
    end
    req_log.delete(); beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    out_val_cnt = 0; resp_rdy_low = 0;
    cmd_cyc0 = cyc + 1;
    @(posedge clk); #1;
    cmd_val        = 1'b0;
    cmd_start_addr = ADDR_W'($urandom);
    cmd_len        = LEN_W'($urandom);
    expect_done    = 1'b1;
    in_cmd         = (len != 0);
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done_cnt), 64'(base + 1));
    @(posedge clk); #1;
    chk("idle_after_done", 64'(busy), 64'(0));
  endtask

  task automatic run_cmd(input int start, input int len);
    int base = done_cnt;
    start_cmd(start, len);
    wait_done(base);
  endtask

  task automatic cmp_reqs(input string nm);
    chk({nm, "_nreq"}, 64'(req_log.size()), 64'(ref_q.size()));
    if (req_log.size() == ref_q.size())
      foreach (ref_q[i]) chk({nm, "_req"}, 64'(req_log[i]), 64'(ref_q[i]));
  endtask

  task automatic cmp_beats(input string nm);
    chk({nm, "_nbeat"}, 64'(beat_data.size()), 64'(ref_b.size()));
    if (beat_data.size() == ref_b.size())
      foreach (ref_b[i]) begin
        chk({nm, "_data"}, beat_data[i], mem[ref_b[i]]);
        chk({nm, "_last"}, 64'(beat_last[i]), 64'(i == ref_b.size() - 1));
      end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, r0, n, start, len;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
    cmd_val = 1'b0; cmd_start_addr = '0; cmd_len = '0;
    rd_req_rdy = 1'b1; out_rdy = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_rdy", 64'(cmd_rdy), 64'(1));
    chk("rst_req_en", 64'(rd_req_en), 64'(0));
    chk("rst_out_val", 64'(out_val), 64'(0));
    chk("rst_out_last", 64'(out_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_resp_rdy", 64'(rd_resp_rdy), 64'(1));
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic read, full throughput
    rmode = 0; omode = 0;
    run_cmd(10, 4);
    ref_q = '{10, 11, 12, 13}; ref_b = '{10, 11, 12, 13};
    cmp_reqs("t1"); cmp_beats("t1");
    if (beat_cyc.size() == 4) chk("t1_back_to_back", 64'(beat_cyc[3] - beat_cyc[0]), 64'(3));

    // Address wrap
    run_cmd(DEPTH - 2, 4);
    ref_q = '{254, 255, 0, 1}; ref_b = '{254, 255, 0, 1};
    cmp_reqs("t2"); cmp_beats("t2");

    // Collision stall on the second request
    rmode = 1;
    run_cmd(10, 4);
    ref_q = '{10, 11, 11, 11, 11, 12, 13}; ref_b = '{10, 11, 12, 13};
    cmp_reqs("t3"); cmp_beats("t3");

    // Output backpressure 1,0,0
    rmode = 0; omode = 1;
    run_cmd(20, 8);
    ref_b = '{20, 21, 22, 23, 24, 25, 26, 27};
    cmp_beats("t4");
    chk("t4_resp_rdy_dropped", 64'(resp_rdy_low > 0), 64'(1));

    // Zero-length command
    omode = 0;
    base = done_cnt;
    start_cmd(5, 0);
    @(negedge clk);
    chk("t5_done_next", 64'(done), 64'(1));
    wait_done(base);
    chk("t5_no_req", 64'(req_log.size()), 64'(0));
    chk("t5_no_out", 64'(out_val_cnt), 64'(0));

    // Reset in the middle of a command
    r0 = resp_acc;
    start_cmd(40, 6);
    n = 0;
    while (resp_acc - r0 < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("t6_two_resps", 64'(resp_acc - r0 >= 2), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cmd_rdy", 64'(cmd_rdy), 64'(1));
    chk("t6_req_en", 64'(rd_req_en), 64'(0));
    chk("t6_out_val", 64'(out_val), 64'(0));
    chk("t6_out_last", 64'(out_last), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_done", 64'(done), 64'(0));
    chk("t6_resp_rdy", 64'(rd_resp_rdy), 64'(1));
    exp_addr.delete(); exp_data.delete(); exp_last.delete();
    occ = 0; in_cmd = 1'b0; expect_done = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(0, 2);
    ref_q = '{0, 1}; ref_b = '{0, 1};
    cmp_reqs("t6b"); cmp_beats("t6b");

    // Randomized commands
    for (int k = 0; k < 40; k++) begin
      rmode = ($urandom % 2 == 0) ? 0 : 2;
      omode = int'($urandom % 3);
      start = int'($urandom % DEPTH);
      len   = ($urandom % 8 == 0) ? int'($urandom_range(0, DEPTH)) : int'($urandom_range(0, 10));
      run_cmd(start, len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
